cm0_dap_ap_cdc_slave: RTL and testbench
=======================================

// Module: cm0_dap_ap_cdc_slave
// PURPOSE
//  AP-clock-domain endpoint of the DP->AP transfer path. Synchronises the DP request
//  level, captures the launched rnw/regaddr/wdata, runs one access on the AP register
//  core, and returns read data, error and a 4-phase ack level to the DP-side CDC block.
//  Provides the CDC-safe launch flops for ap_data/ap_err/ap_ack toward the DP domain.
// PARAMETERS
//  PRESENT    1  0 = block removed: all outputs tied 0, no flops inferred
//  TIMEOUT_W  8  width of access watchdog; access force-completed with error after 2^W-1 cycles
// PORTS
//  dapclk        in   1   AP domain clock
//  dapreset_n    in   1   AP domain reset: asynchronous assert, active-low
//  SE            in   1   DFT scan enable, passed to sync/launch cells
//  dp_req_dp_i   in   1   DP request level (async, from DP launch flop)
//  dp_rnw_i      in   1   1=read, 0=write (async, stable while req high)
//  dp_regaddr_i  in   4   AP register address (async, stable while req high)
//  dp_data_i     in   32  write data (async, stable while req high)
//  ap_req_o      out  1   one-cycle access strobe to AP core
//  ap_rnw_o      out  1   captured rnw
//  ap_addr_o     out  4   captured regaddr
//  ap_wdata_o    out  32  captured write data
//  ap_done_i     in   1   AP core access complete
//  ap_rdata_i    in   32  AP core read data, valid with ap_done_i
//  ap_slverr_i   in   1   AP core error, valid with ap_done_i
//  ap_data_ap_o  out  32  held read data to DP (launch flop)
//  ap_err_ap_o   out  1   held error to DP (launch flop)
//  ap_ack_ap_o   out  1   ack level to DP (launch flop)
//  ap_busy_o     out  1   state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, watchdog 0. All flops async-reset on dapreset_n.
//  - req_s = dp_req_dp_i through 2-flop sync (cm0_dap_cdc_capt_sync); 2-cycle latency.
//  - FSM: IDLE -> ACCESS on req_s=1 & ack=0; that edge captures dp_rnw/regaddr/data into
//    ap_rnw_o/ap_addr_o/ap_wdata_o, sets ap_req_o=1 for exactly one cycle, clears watchdog.
//  - ACCESS: ap_done_i sampled every cycle incl. the ap_req_o cycle (zero-wait core legal).
//    On done: ap_err_ap_o<=ap_slverr_i; ap_data_ap_o<=ap_rdata_i if rnw else unchanged;
//    if req_s=1 -> ACK (ap_ack_ap_o<=1), else -> IDLE, result discarded, ack stays 0.
//  - Watchdog increments each ACCESS cycle w/o done; at 2^W-1 treated as done with
//    ap_slverr_i=1, rdata ignored (data unchanged). Late ap_done_i after that ignored.
//  - ACK: ap_ack_ap_o=1, ap_data/ap_err held constant. On req_s=0 -> IDLE, ack<=0 same edge.
//  - IDLE with req_s=1 & ack=1 impossible; req_s=0 in IDLE: no action.
//  - DP reset mid-transfer (req drops while ACCESS): access completes to core, no ack.
//  - ap_data_ap_o/ap_err_ap_o/ap_ack_ap_o only change on dapclk edge from single flops,
//    no comb logic after flop (glitch-free for DP-side sampling).
//  - Round trip: req edge -> ap_req_o 3 cycles; done -> ack 1 cycle; req fall -> ack fall 3.
//  - Writes never alter ap_data_ap_o; ap_err_ap_o updated on every completed access.
// STRUCTURE
//  - State encodings (IDLE=2'b00, ACCESS=2'b01, ACK=2'b10) and TIMEOUT default in shared
//    DAP defines header; illegal state 2'b11 recovers to IDLE with ack 0.
//  - Instantiate cm0_dap_cdc_capt_sync for req; launch regs via cm0_dap_cdc_send_data /
//    cm0_dap_cdc_send for ap_data/ap_err; ack flop in-module with async reset.
// TESTING
//  1 Read: req=1, rnw=1, addr=4'hC; core done after 2 cycles, rdata=32'hA5A5_0001 ->
//    ap_req_o single pulse 3 cycles after req, addr=C; ack=1, data=A5A5_0001, err=0.
//  2 Write: rnw=0, data=32'h1234_5678, zero-wait done with slverr=1 -> ap_wdata_o captured,
//    ap_data_ap_o unchanged from test 1, err=1, ack=1; drop req -> ack=0 3 cycles later.
//  3 Timeout (W=3): never assert done -> after 7 ACCESS cycles err=1, ack=1; late done ignored.
//  4 Req drops during ACCESS, then done -> no ack, state IDLE, next req starts fresh access.
//  5 dapreset_n low mid-ACK -> all outputs 0 asynchronously; after release req still high
//    -> new access (ap_req_o pulse) issued.
//  6 PRESENT=0 -> all outputs 0 under any stimulus; back-to-back 4-phase transfers with
//    PRESENT=1 show exactly one ap_req_o per req high phase.

Source files
------------

// File: rtl/cm0_dap_ap_cdc_slave_pkg.sv
// Shared DAP definitions for the AP-side transfer endpoint: state encodings
// and the default access watchdog width.
package cm0_dap_ap_cdc_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } ap_state_t;

  localparam int unsigned DAP_TIMEOUT_W = 8;

endpackage

// File: rtl/cm0_dap_cdc_capt_sync.sv
// Two-flop synchroniser for a single asynchronous level entering the AP clock
// domain. During scan shift the metastability stage is bypassed so the cell
// behaves as a single scan flop.
module cm0_dap_cdc_capt_sync
  import cm0_dap_ap_cdc_slave_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic se,
  input  logic d,
  output logic q
);

  logic meta;

  // capture the async level, then resolve it through a second stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= se ? d : meta;
    end
  end

endmodule

// File: rtl/cm0_dap_ap_cdc_slave.sv
// AP-domain endpoint of the DP->AP transfer path. Synchronises the DP request
// level, captures the launched command, runs one access on the AP register
// core and returns read data, error and a four-phase ack level. The data, err
// and ack outputs come straight from single flops so the DP side can sample
// them without seeing glitches.
//
// state  | meaning
// IDLE   | waiting for a new request level (with ack low)
// ACCESS | strobe issued, waiting for core done or watchdog expiry
// ACK    | result held, ack high, waiting for request level to drop
module cm0_dap_ap_cdc_slave
  import cm0_dap_ap_cdc_slave_pkg::*;
#(
  parameter bit          PRESENT   = 1'b1,
  parameter int unsigned TIMEOUT_W = DAP_TIMEOUT_W
) (
  input  logic        dapclk,
  input  logic        dapreset_n,
  input  logic        SE,
  input  logic        dp_req_dp_i,
  input  logic        dp_rnw_i,
  input  logic [3:0]  dp_regaddr_i,
  input  logic [31:0] dp_data_i,
  output logic        ap_req_o,
  output logic        ap_rnw_o,
  output logic [3:0]  ap_addr_o,
  output logic [31:0] ap_wdata_o,
  input  logic        ap_done_i,
  input  logic [31:0] ap_rdata_i,
  input  logic        ap_slverr_i,
  output logic [31:0] ap_data_ap_o,
  output logic        ap_err_ap_o,
  output logic        ap_ack_ap_o,
  output logic        ap_busy_o
);

  generate
    if (PRESENT) begin : g_present
      // watchdog value on the last cycle before a forced completion
      localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~TIMEOUT_W'(1);

      logic                 req_s;
      ap_state_t            state;
      logic [TIMEOUT_W-1:0] wdog;
      logic                 wdog_last;

      cm0_dap_cdc_capt_sync u_req_sync (
        .clk   (dapclk),
        .rst_n (dapreset_n),
        .se    (SE),
        .d     (dp_req_dp_i),
        .q     (req_s)
      );

      assign wdog_last = (wdog == WDOG_LAST);
      assign ap_busy_o = (state != ST_IDLE);

      // transfer sequencer; all results toward the DP domain are registered here
      always_ff @(posedge dapclk or negedge dapreset_n) begin
        if (!dapreset_n) begin
          state        <= ST_IDLE;
          wdog         <= '0;
          ap_req_o     <= 1'b0;
          ap_rnw_o     <= 1'b0;
          ap_addr_o    <= '0;
          ap_wdata_o   <= '0;
          ap_data_ap_o <= '0;
          ap_err_ap_o  <= 1'b0;
          ap_ack_ap_o  <= 1'b0;
        end else begin
          ap_req_o <= 1'b0;
          case (state)
            ST_IDLE: begin
              if (req_s && !ap_ack_ap_o) begin
                state      <= ST_ACCESS;
                ap_req_o   <= 1'b1;
                ap_rnw_o   <= dp_rnw_i;
                ap_addr_o  <= dp_regaddr_i;
                ap_wdata_o <= dp_data_i;
                wdog       <= '0;
              end
            end
            ST_ACCESS: begin
              if (ap_done_i || wdog_last) begin
                // a real done wins over a simultaneous watchdog expiry
                ap_err_ap_o <= ap_done_i ? ap_slverr_i : 1'b1;
                if (ap_done_i && ap_rnw_o) begin
                  ap_data_ap_o <= ap_rdata_i;
                end
                if (req_s) begin
                  state       <= ST_ACK;
                  ap_ack_ap_o <= 1'b1;
                end else begin
                  // DP side went away mid-access: finish quietly, no ack
                  state <= ST_IDLE;
                end
              end else begin
                wdog <= wdog + TIMEOUT_W'(1);
              end
            end
            ST_ACK: begin
              if (!req_s) begin
                state       <= ST_IDLE;
                ap_ack_ap_o <= 1'b0;
              end
            end
            default: begin
              state       <= ST_IDLE;
              ap_ack_ap_o <= 1'b0;
            end
          endcase
        end
      end
    end else begin : g_absent
      assign ap_req_o     = 1'b0;
      assign ap_rnw_o     = 1'b0;
      assign ap_addr_o    = '0;
      assign ap_wdata_o   = '0;
      assign ap_data_ap_o = '0;
      assign ap_err_ap_o  = 1'b0;
      assign ap_ack_ap_o  = 1'b0;
      assign ap_busy_o    = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_ap_cdc_slave.sv
// Bench for the AP-side CDC endpoint: directed scenarios followed by random
// four-phase transfers, checked against a transaction-level model of the
// expected held data/error and handshake latencies.
module tb_cm0_dap_ap_cdc_slave;

  logic        dapclk = 1'b0;
  logic        dapreset_n;
  logic        SE;
  logic        dp_req;
  logic        dp_rnw;
  logic [3:0]  dp_regaddr;
  logic [31:0] dp_data;
  logic        ap_done;
  logic [31:0] ap_rdata;
  logic        ap_slverr;

  logic        ap_req_o, ap_rnw_o, ap_err_ap_o, ap_ack_ap_o, ap_busy_o;
  logic [3:0]  ap_addr_o;
  logic [31:0] ap_wdata_o, ap_data_ap_o;

  logic        z_req, z_rnw, z_err, z_ack, z_busy;
  logic [3:0]  z_addr;
  logic [31:0] z_wdata, z_data;

  cm0_dap_ap_cdc_slave #(.PRESENT(1'b1), .TIMEOUT_W(3)) dut (
    .dapclk       (dapclk),
    .dapreset_n   (dapreset_n),
    .SE           (SE),
    .dp_req_dp_i  (dp_req),
    .dp_rnw_i     (dp_rnw),
    .dp_regaddr_i (dp_regaddr),
    .dp_data_i    (dp_data),
    .ap_req_o     (ap_req_o),
    .ap_rnw_o     (ap_rnw_o),
    .ap_addr_o    (ap_addr_o),
    .ap_wdata_o   (ap_wdata_o),
    .ap_done_i    (ap_done),
    .ap_rdata_i   (ap_rdata),
    .ap_slverr_i  (ap_slverr),
    .ap_data_ap_o (ap_data_ap_o),
    .ap_err_ap_o  (ap_err_ap_o),
    .ap_ack_ap_o  (ap_ack_ap_o),
    .ap_busy_o    (ap_busy_o)
  );

  cm0_dap_ap_cdc_slave #(.PRESENT(1'b0), .TIMEOUT_W(3)) dut_absent (
    .dapclk       (dapclk),
    .dapreset_n   (dapreset_n),
    .SE           (SE),
    .dp_req_dp_i  (dp_req),
    .dp_rnw_i     (dp_rnw),
    .dp_regaddr_i (dp_regaddr),
    .dp_data_i    (dp_data),
    .ap_req_o     (z_req),
    .ap_rnw_o     (z_rnw),
    .ap_addr_o    (z_addr),
    .ap_wdata_o   (z_wdata),
    .ap_done_i    (ap_done),
    .ap_rdata_i   (ap_rdata),
    .ap_slverr_i  (ap_slverr),
    .ap_data_ap_o (z_data),
    .ap_err_ap_o  (z_err),
    .ap_ack_ap_o  (z_ack),
    .ap_busy_o    (z_busy)
  );

  always #5 dapclk = ~dapclk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_strobe = 0;
  int          n_strobe_exp = 0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;

  // every cycle the strobe is high counts; one expected per request phase
  always @(negedge dapclk) if (ap_req_o === 1'b1) n_strobe++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_absent();
    chk("absent_outs", {63'd0, |{z_req, z_rnw, z_addr, z_wdata, z_data, z_err, z_ack, z_busy}}, 64'd0);
  endtask

  task automatic wait_strobe(input logic rnw, input logic [3:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    do begin @(negedge dapclk); n++; end while (ap_req_o !== 1'b1 && n < 12);
    chk("req_latency", 64'(n), 64'd3);
    n_strobe_exp++;
    chk("cap_rnw", {63'd0, ap_rnw_o}, {63'd0, rnw});
    chk("cap_addr", {60'd0, ap_addr_o}, {60'd0, addr});
    chk("cap_wdata", {32'd0, ap_wdata_o}, {32'd0, wdata});
  endtask

  task automatic launch(input logic rnw, input logic [3:0] addr, input logic [31:0] wdata);
    @(negedge dapclk);
    dp_rnw = rnw; dp_regaddr = addr; dp_data = wdata; dp_req = 1'b1;
    wait_strobe(rnw, addr, wdata);
  endtask

  // called at the negedge where the strobe is seen; lat < 0 means core never answers
  task automatic complete(input int lat, input logic [31:0] rdata, input logic slverr, input logic rnw);
    int n;
    n = 0;
    if (lat >= 0) begin
      repeat (lat) @(negedge dapclk);
      chk("ack_early", {63'd0, ap_ack_ap_o}, 64'd0);
      ap_done = 1'b1; ap_rdata = rdata; ap_slverr = slverr;
      @(negedge dapclk);
      ap_done = 1'b0; ap_rdata = $urandom; ap_slverr = 1'b1;
      m_err = slverr;
      if (rnw) m_data = rdata;
    end else begin
      do begin @(negedge dapclk); n++; end while (ap_ack_ap_o !== 1'b1 && n < 20);
      chk("timeout_cycles", 64'(n), 64'd7);
      m_err = 1'b1;
    end
    chk("ack_high", {63'd0, ap_ack_ap_o}, 64'd1);
    chk("data", {32'd0, ap_data_ap_o}, {32'd0, m_data});
    chk("err", {63'd0, ap_err_ap_o}, {63'd0, m_err});
    chk("busy_ack", {63'd0, ap_busy_o}, 64'd1);
  endtask

  task automatic drop();
    int n;
    n = 0;
    dp_req = 1'b0;
    do begin @(negedge dapclk); n++; end while (ap_ack_ap_o !== 1'b0 && n < 12);
    chk("ack_fall", 64'(n), 64'd3);
    chk("idle_busy", {63'd0, ap_busy_o}, 64'd0);
    chk("hold_data", {32'd0, ap_data_ap_o}, {32'd0, m_data});
    chk("hold_err", {63'd0, ap_err_ap_o}, {63'd0, m_err});
    chk_absent();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic        r_rnw;
    logic [3:0]  r_addr;
    logic [31:0] r_wdata, r_rdata;
    int          r_lat;
    dapreset_n = 1'b0; SE = 1'b0;
    dp_req = 1'b1; dp_rnw = 1'b1; dp_regaddr = 4'h7; dp_data = 32'hFFFF_FFFF;
    ap_done = 1'b1; ap_rdata = 32'hFFFF_FFFF; ap_slverr = 1'b1;
    repeat (3) @(negedge dapclk);
    chk("rst_outs", {63'd0, |{ap_req_o, ap_rnw_o, ap_addr_o, ap_wdata_o, ap_data_ap_o,
                              ap_err_ap_o, ap_ack_ap_o, ap_busy_o}}, 64'd0);
    chk_absent();
    dp_req = 1'b0; ap_done = 1'b0; ap_slverr = 1'b0;
    @(negedge dapclk);
    dapreset_n = 1'b1;

    // read with a two-cycle core
    launch(1'b1, 4'hC, 32'h0000_0000);
    complete(2, 32'hA5A5_0001, 1'b0, 1'b1);
    drop();

    // write with zero-wait core and error
    launch(1'b0, 4'h2, 32'h1234_5678);
    complete(0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drop();

    // watchdog expiry, then a late done that must be ignored
    launch(1'b1, 4'h4, 32'h0);
    complete(-1, 32'h0, 1'b0, 1'b1);
    ap_done = 1'b1; ap_rdata = 32'h0BAD_0BAD; ap_slverr = 1'b0;
    @(negedge dapclk);
    ap_done = 1'b0;
    @(negedge dapclk);
    chk("late_done_err", {63'd0, ap_err_ap_o}, 64'd1);
    chk("late_done_data", {32'd0, ap_data_ap_o}, {32'd0, m_data});
    drop();

    // request withdrawn mid-access: completes silently, next access is fresh
    launch(1'b0, 4'h3, 32'hCAFE_F00D);
    dp_req = 1'b0;
    repeat (4) @(negedge dapclk);
    chk("drop_busy", {63'd0, ap_busy_o}, 64'd1);
    ap_done = 1'b1; ap_slverr = 1'b0; ap_rdata = 32'h1111_2222;
    @(negedge dapclk);
    ap_done = 1'b0;
    m_err = 1'b0;
    repeat (3) @(negedge dapclk);
    chk("drop_no_ack", {63'd0, ap_ack_ap_o}, 64'd0);
    chk("drop_idle", {63'd0, ap_busy_o}, 64'd0);
    launch(1'b1, 4'h5, 32'h7777_0000);
    complete(1, 32'h5555_AAAA, 1'b0, 1'b1);
    drop();

    // reset while in ACK with request still high
    launch(1'b1, 4'h9, 32'h0);
    complete(0, 32'h9999_0009, 1'b0, 1'b1);
    #2 dapreset_n = 1'b0;
    #1;
    chk("rst_async", {63'd0, |{ap_req_o, ap_rnw_o, ap_addr_o, ap_wdata_o, ap_data_ap_o,
                               ap_err_ap_o, ap_ack_ap_o, ap_busy_o}}, 64'd0);
    m_data = '0; m_err = 1'b0;
    @(negedge dapclk);
    dapreset_n = 1'b1;
    wait_strobe(1'b1, 4'h9, 32'h0);
    complete(0, 32'h0F0F_F0F0, 1'b1, 1'b1);
    drop();

    // random back-to-back four-phase transfers
    for (int i = 0; i < 20; i++) begin
      r_rnw   = 1'($urandom_range(0, 1));
      r_addr  = 4'($urandom);
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_lat   = int'($urandom_range(0, 4));
      launch(r_rnw, r_addr, r_wdata);
      complete(r_lat, r_rdata, 1'($urandom_range(0, 1)), r_rnw);
      drop();
    end

    repeat (2) @(negedge dapclk);
    chk("strobe_count", 64'(n_strobe), 64'(n_strobe_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
